uart_rx: RTL
============

# uart_rx

Serial UART receiver, counterpart of the team's `uart_tx`, driven by the same shared 16× oversampling tick from `baud_gen`. It synchronises the asynchronous `rx` line, finds the start bit, samples each data bit at mid-bit and checks the stop bit. For each frame it presents one byte with a single-cycle completion pulse and a framing-error flag. It sits between the pad and the RX-side FIFO or consumer logic.

## Interface
Parameters:
- `DBIT`, 8: data bits per frame, LSB first.
- `SB_TICK`, 16: oversampling ticks in the stop phase (16/24/32 = 1/1.5/2 stop bits).

Ports:
- `clk`, in, 1: single clock; all logic on posedge.
- `reset`, in, 1: synchronous, active-high.
- `s_tick`, in, 1: 16× baud enable, one-cycle pulse from `baud_gen`.
- `rx`, in, 1: asynchronous serial input, idle high.
- `dout`, out, `DBIT`: last received byte; holds until the next frame completes.
- `rx_done_tick`, out, 1: one-cycle pulse at frame end, good or bad.
- `frame_err`, out, 1: one-cycle pulse with `rx_done_tick` when the stop bit samples low.

## Operation
- **Input synchronizer.** `rx` passes through a 2-flop synchronizer. Both flops reset to 1. The FSM sees only `rx_s`.
- **Registers.** `state`, `s_reg` (4 bits), `n_reg` (`$clog2(DBIT)` bits), `b_reg` (`DBIT` bits).
  - Counters advance only on cycles with `s_tick`=1.
  - Without `s_tick`, only the idle-to-start transition can happen.
- **idle:**
  - When `rx_s`=0, set `s_reg`=0 and go to start. This does not wait for a tick.
- **start:**
  - On a tick with `s_reg`==7 (mid start bit):
    - If `rx_s`=0: set `s_reg`=0, `n_reg`=0, go to data.
    - If `rx_s`=1: treat as a glitch (false start). Return to idle with no pulse.
  - On other ticks, `s_reg`++.
- **data:**
  - On a tick with `s_reg`==15:
    - Set `s_reg`=0.
    - Shift right: `b_reg` = {`rx_s`, `b_reg[DBIT-1:1]`}.
    - If `n_reg`==`DBIT-1`, go to stop; else `n_reg`++.
  - On other ticks, `s_reg`++.
- **stop:**
  - On a tick with `s_reg`==`SB_TICK-1`:
    - Update `dout` with `b_reg`.
    - Pulse `rx_done_tick`=1.
    - Pulse `frame_err`=~`rx_s`.
    - Go to idle.
  - On other ticks, `s_reg`++.
  - `s_reg` must be wide enough for `SB_TICK-1`; use `$clog2(SB_TICK)` bits, minimum 4.
- **Framing error.** A bad frame still updates `dout`. A low line after the stop phase is re-detected as a new start bit in idle, which gives break-condition behaviour.

## Timing
- **Reset values:**
  - State is idle.
  - All counters are 0.
  - `b_reg` and `dout` are 0.
  - `rx_done_tick`, `frame_err` are 0.
  - Synchronizer flops are 1.
- `dout`, `rx_done_tick` and `frame_err` are registered outputs. `rx_done_tick` and `frame_err` assert in the cycle after the final stop tick and last exactly one clock.
- **Latency.**
  - From a falling `rx` to leaving idle: 3 clocks (2 synchronizer + 1 FSM).
  - Frame end occurs 8 + 16·`DBIT` + `SB_TICK` ticks after start detection (152 ticks at the defaults).
- `reset` asserted mid-frame aborts the frame: no pulse, `dout` cleared, synchronizer back to 1.
- `s_tick` held high continuously is legal; the counters then advance every clock.
- With back-to-back frames, the next start edge is detected in the first idle cycle after the done pulse.

## Structure
- **Package `uart_pkg`** (shared with `uart_tx`) holds:
  - `typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t`
  - `localparam int OVERSAMPLE = 16`
  - `localparam int MID_TICK = OVERSAMPLE/2 - 1`
- **Sub-module `sync_2ff`:** a generic 1-bit, 2-stage synchronizer with a reset value parameter. It is reused for other async inputs.
- Everything else stays in one module: a registered-state FSM with a separate next-state combinational block.

## Test plan
All scenarios use a `baud_gen` tick every 4 clocks and drive `rx` through a task that emits bits 16 ticks wide.

- **Single frame.** Send 0xA5 with 1 stop bit → one `rx_done_tick`, `dout`=0xA5, `frame_err`=0. The pulse is exactly 1 clock wide.
- **Back-to-back frames.** Send 0x00, 0xFF, 0x55 with no idle gap → three pulses, `dout` values in that order, no errors.
- **False start.** Pulse `rx` low for 4 ticks, then high → no `rx_done_tick`, FSM back in idle. A following 0x3C is received correctly.
- **Framing error.** Send 0x81 with the stop bit driven low → `rx_done_tick`=1 and `frame_err`=1 in the same cycle, `dout`=0x81.
- **Reset mid-frame.** Assert `reset` for 1 clock during data bit 3 of 0xC3 → no pulse, `dout`=0. The next frame 0x7E is received intact.
- **Parameter sweep.** `DBIT`=7, `SB_TICK`=32, send 0x5A → `dout`=0x5A, pulse 8+112+32 ticks after start detection.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling constants and a
// counter-width helper used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = OVERSAMPLE / 2 - 1;

    // Bits needed to count 0..max_count-1, never narrower than min_width.
    function automatic int cnt_width(input int max_count, input int min_width);
        int w;
        w = $clog2(max_count);
        if (w > min_width) begin
            return w;
        end else begin
            return min_width;
        end
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-stage synchronizer for asynchronous inputs, with a
// selectable reset value so idle-high lines come out of reset inactive.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two flops in series; the first may go metastable, the second settles it.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver using the shared 16x oversampling tick: mid-bit sampling,
// LSB-first data, one-cycle done pulse with a framing-error flag.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err
);

    localparam int SW = cnt_width(SB_TICK, 4);
    localparam int NW = cnt_width(DBIT, 1);

    localparam logic [SW-1:0] S_MID  = SW'(MID_TICK);
    localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    logic            rx_s;
    uart_state_t     state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            done_q, done_d;
    logic            ferr_q, ferr_d;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk_i   (clk),
        .reset_i (reset),
        .d_i     (rx),
        .q_o     (rx_s)
    );

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= {SW{1'b0}};
            n_q     <= {NW{1'b0}};
            b_q     <= {DBIT{1'b0}};
            dout_q  <= {DBIT{1'b0}};
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    // Next-state logic; only the idle-to-start step ignores s_tick.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    s_d     = {SW{1'b0}};
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == S_MID) begin
                        // A line back high at mid start bit was only a glitch.
                        if (!rx_s) begin
                            s_d     = {SW{1'b0}};
                            n_d     = {NW{1'b0}};
                            state_d = DATA;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end else begin
                    s_d = s_q;
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == S_BIT) begin
                        s_d = {SW{1'b0}};
                        b_d = {rx_s, b_q[DBIT-1:1]};
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end else begin
                    s_d = s_q;
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == S_STOP) begin
                        dout_d  = b_q;
                        done_d  = 1'b1;
                        ferr_d  = ~rx_s;
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end else begin
                    s_d = s_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dout         = dout_q;
    assign rx_done_tick = done_q;
    assign frame_err    = ferr_q;

endmodule
